rx_frame_checker: RTL and testbench
===================================

# rx_frame_checker

Receive-side frame checker at the far end of the PSK link. It consumes the demodulator's byte stream (data_tdata/tvalid/tuser/tlast) in the 1.024 MHz domain. It validates frame length, checksum and sequence continuity against the framing that the transmit data source emits, and exposes pulses, counters and a lock flag for loopback and over-the-air bit-error measurement.

## Interface
Parameters:
- PAYLOAD_LEN, 16: payload bytes per frame (2..250); total frame = PAYLOAD_LEN+2 beats.
- CNT_W, 16: width of all statistics counters.
- LOCK_N, 4: consecutive good, in-sequence frames required to assert locked (1..15).

Ports:
- clk_1M024  in  1  byte clock, all logic on rising edge.
- rst_n_1M024  in  1  synchronous active-low reset.
- data_tdata  in  8  received byte.
- data_tvalid  in  1  beat qualifier; no backpressure, every valid beat must be consumed.
- data_tuser  in  1  first beat of frame (sequence byte).
- data_tlast  in  1  last beat of frame (checksum byte).
- clr  in  1  synchronous clear of counters and lock; FSM unaffected.
- frame_ok  out  1  one-cycle pulse: frame passed length and checksum.
- frame_bad  out  1  one-cycle pulse: frame failed.
- seq_gap  out  1  one-cycle pulse, coincident with frame_ok, when seq ≠ previous good seq+1.
- locked  out  1  LOCK_N consecutive frame_ok without seq_gap.
- last_seq  out  8  sequence byte of the most recent good frame.
- ok_cnt, bad_cnt, gap_cnt, bit_err_cnt  out  CNT_W each  saturating counters.

## Operation
- Frame format: beat 0 = seq (tuser=1); beats 1..PAYLOAD_LEN = payload; beat PAYLOAD_LEN+1 = checksum (tlast=1). Checksum = (seq + Σpayload) mod 256.
- FSM states: HUNT, BODY, SKIP.
  - HUNT: ignore beats until tvalid&tuser. Then load seq, set sum=tdata, idx=1, and go to BODY. A beat with tuser&tlast together is bad: pulse frame_bad and stay in HUNT.
  - BODY: on each valid beat, if idx<PAYLOAD_LEN+1, accumulate sum and increment idx.
    - tlast before idx=PAYLOAD_LEN+1 → bad, go to HUNT.
    - At idx=PAYLOAD_LEN+1: tlast=1 with tdata==sum → good, go to HUNT. tlast=1 with mismatch → bad, go to HUNT. tlast=0 → bad, go to SKIP.
  - SKIP: discard beats until a tlast beat (→HUNT) or a tuser beat (restart as from HUNT, no extra bad).
  - tuser in BODY: current frame is bad. The same beat starts a new frame (seq loaded, idx=1).
- Sequence: the first good frame after reset/clr, or after any bad frame, sets the reference without seq_gap. Afterwards a good frame with seq ≠ (last_seq+1) mod 256 pulses seq_gap and increments gap_cnt. last_seq updates on every good frame.
- Lock: a run counter increments on frame_ok without seq_gap, resets to 0 on frame_bad or seq_gap. locked=1 when run≥LOCK_N, and clears in the cycle after any frame_bad or seq_gap.
- Counters saturate at 2^CNT_W−1. clr zeroes them plus run/locked and re-arms the sequence reference; clr has priority over same-cycle increments.
- tvalid=0 cycles are idle: state holds, no timeout.

## Timing
- Reset values: frame_ok=frame_bad=seq_gap=0, locked=0, last_seq=0, all counters 0, FSM=HUNT, idx=0, sum=0.
- All outputs are registered. The pulses assert exactly one cycle after the deciding beat (tlast beat, early tuser, or missing-tlast beat) and last one cycle.
- Counters and last_seq update in the same cycle as the corresponding pulse. locked updates one cycle after the pulse.
- Back-to-back frames (tlast beat immediately followed by tuser beat) are accepted with no gap.
- Reset mid-frame discards partial state; the next tuser beat starts cleanly.

## Configuration
- RX_CHK_PATTERN_EN: when defined, payload byte k (1-based) of a frame must equal (seq+k) mod 256. The popcount of (tdata XOR expected) is added to bit_err_cnt on each payload beat, including beats of frames later declared bad. Pattern errors alone do not make a frame bad.
- When undefined, no pattern logic is built and bit_err_cnt is tied to 0.

## Test plan
- Reset, then 5 well-formed frames seq 0x10..0x14, PAYLOAD_LEN=16 → 5 frame_ok, ok_cnt=5, gap_cnt=0, locked=1 after the 4th frame_ok, last_seq=0x14.
- Good frame seq 0x20 followed by good frame seq 0x22 → second gives frame_ok+seq_gap, gap_cnt=1, locked drops.
- Checksum byte XOR 0x01 → frame_bad, bad_cnt=1, ok_cnt unchanged; next good frame sets reference without seq_gap.
- tlast on beat 10, then tuser on beat 5 of the next frame followed by a full frame → two frame_bad, then frame_ok.
- With RX_CHK_PATTERN_EN defined, flip bits 0 and 7 of payload byte 3 (correct checksum recomputed) → frame_ok, bit_err_cnt=2; assert clr → all counters 0, locked=0.
- Drive ok_cnt to saturation with CNT_W=4 (16+ good frames) → ok_cnt holds 15.

Source files
------------

// File: rtl/rx_frame_checker.sv
// rx_frame_checker: receive-side frame checker for the PSK link byte stream.
//
// Validates frame length and checksum (seq + sum(payload) mod 256) and
// sequence continuity, then reports per-frame pulses, saturating statistics
// counters and a lock flag. All logic runs on the rising edge of clk_1M024.
//
// Optional feature macro: RX_CHK_PATTERN_EN
//   When defined, payload byte k must equal (seq+k) mod 256 and the bit
//   errors against that pattern are accumulated into bit_err_cnt. When
//   undefined, no pattern logic is built and bit_err_cnt reads 0.
//
// Ports:
//   clk_1M024, rst_n_1M024  byte clock, synchronous active-low reset
//   data_t{data,valid,user,last}  received byte stream (no backpressure)
//   clr          synchronous clear of counters, lock and sequence reference
//   frame_ok     one-cycle pulse, frame passed length and checksum
//   frame_bad    one-cycle pulse, frame failed
//   seq_gap      one-cycle pulse with frame_ok when seq != previous good seq+1
//   locked       LOCK_N consecutive in-sequence good frames
//   last_seq     sequence byte of the most recent good frame
//   ok_cnt, bad_cnt, gap_cnt, bit_err_cnt  saturating counters
module rx_frame_checker #(
  parameter int unsigned PAYLOAD_LEN = 16,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LOCK_N      = 4
) (
  input  logic             clk_1M024,
  input  logic             rst_n_1M024,
  input  logic [7:0]       data_tdata,
  input  logic             data_tvalid,
  input  logic             data_tuser,
  input  logic             data_tlast,
  input  logic             clr,
  output logic             frame_ok,
  output logic             frame_bad,
  output logic             seq_gap,
  output logic             locked,
  output logic [7:0]       last_seq,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] bad_cnt,
  output logic [CNT_W-1:0] gap_cnt,
  output logic [CNT_W-1:0] bit_err_cnt
);

  // Index of the checksum beat within a frame.
  localparam logic [7:0] LastIdx = 8'(PAYLOAD_LEN + 1);

  typedef enum logic [1:0] {StHunt, StBody, StSkip} state_e;

  state_e           state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       sum_q, sum_d;
  logic [7:0]       seq_q, seq_d;
  logic [7:0]       last_seq_q, last_seq_d;
  logic             frame_ok_q, frame_bad_q, seq_gap_q, locked_q;
  logic             ref_q, ref_d;
  logic [3:0]       run_q, run_d;
  logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             good_evt, bad_evt, gap_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Frame FSM: decides good/bad on the deciding beat.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    seq_d    = seq_q;
    good_evt = 1'b0;
    bad_evt  = 1'b0;
    if (data_tvalid) begin
      unique case (state_q)
        StHunt, StSkip: begin
          if (data_tuser) begin
            if (data_tlast) begin
              // A one-beat frame can never be valid.
              bad_evt = 1'b1;
              state_d = StHunt;
            end else begin
              seq_d   = data_tdata;
              sum_d   = data_tdata;
              idx_d   = 8'd1;
              state_d = StBody;
            end
          end else if (state_q == StSkip && data_tlast) begin
            state_d = StHunt;
          end
        end
        StBody: begin
          if (data_tuser) begin
            // Early start of frame: abort current frame, same beat restarts.
            bad_evt = 1'b1;
            if (data_tlast) begin
              state_d = StHunt;
            end else begin
              seq_d = data_tdata;
              sum_d = data_tdata;
              idx_d = 8'd1;
            end
          end else if (idx_q < LastIdx) begin
            if (data_tlast) begin
              bad_evt = 1'b1;
              state_d = StHunt;
            end else begin
              sum_d = sum_q + data_tdata;
              idx_d = idx_q + 8'd1;
            end
          end else if (data_tlast) begin
            good_evt = (data_tdata == sum_q);
            bad_evt  = (data_tdata != sum_q);
            state_d  = StHunt;
          end else begin
            // Frame overran its length; drop the rest of it.
            bad_evt = 1'b1;
            state_d = StSkip;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  assign gap_evt = good_evt && ref_q && (seq_q != last_seq_q + 8'd1);

  // Statistics next-state; clr wins over same-cycle events.
  always_comb begin
    last_seq_d = good_evt ? seq_q : last_seq_q;
    ok_cnt_d   = ok_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    run_d      = run_q;
    ref_d      = ref_q;
    if (clr) begin
      ok_cnt_d  = '0;
      bad_cnt_d = '0;
      gap_cnt_d = '0;
      run_d     = '0;
      ref_d     = 1'b0;
    end else begin
      if (good_evt) ok_cnt_d = sat_inc(ok_cnt_q);
      if (bad_evt) bad_cnt_d = sat_inc(bad_cnt_q);
      if (gap_evt) gap_cnt_d = sat_inc(gap_cnt_q);
      if (bad_evt || gap_evt) begin
        run_d = '0;
      end else if (good_evt && run_q != 4'(LOCK_N)) begin
        run_d = run_q + 4'd1;
      end
      if (good_evt) begin
        ref_d = 1'b1;
      end else if (bad_evt) begin
        ref_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_1M024) begin
    if (!rst_n_1M024) begin
      state_q     <= StHunt;
      idx_q       <= '0;
      sum_q       <= '0;
      seq_q       <= '0;
      last_seq_q  <= '0;
      frame_ok_q  <= 1'b0;
      frame_bad_q <= 1'b0;
      seq_gap_q   <= 1'b0;
      locked_q    <= 1'b0;
      ref_q       <= 1'b0;
      run_q       <= '0;
      ok_cnt_q    <= '0;
      bad_cnt_q   <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      seq_q       <= seq_d;
      last_seq_q  <= last_seq_d;
      frame_ok_q  <= good_evt;
      frame_bad_q <= bad_evt;
      seq_gap_q   <= gap_evt;
      // Follows run_q, so lock lags the deciding pulse by one cycle.
      locked_q    <= clr ? 1'b0 : (run_q >= 4'(LOCK_N));
      ref_q       <= ref_d;
      run_q       <= run_d;
      ok_cnt_q    <= ok_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

`ifdef RX_CHK_PATTERN_EN
  logic [CNT_W-1:0] bit_err_q, bit_err_d;
  logic [CNT_W+3:0] bit_err_acc;
  logic [7:0]       pat_exp;
  logic [3:0]       pat_pop;
  logic             pay_beat;

  // Payload beats only; counted even if the frame is later declared bad.
  always_comb begin
    pay_beat    = data_tvalid && (state_q == StBody) && !data_tuser && !data_tlast &&
                  (idx_q < LastIdx);
    pat_exp     = seq_q + idx_q;
    pat_pop     = 4'($countones(data_tdata ^ pat_exp));
    bit_err_acc = (CNT_W+4)'(bit_err_q) + (CNT_W+4)'(pat_pop);
    bit_err_d   = bit_err_q;
    if (clr) begin
      bit_err_d = '0;
    end else if (pay_beat) begin
      if (bit_err_acc > (CNT_W+4)'({CNT_W{1'b1}})) begin
        bit_err_d = '1;
      end else begin
        bit_err_d = bit_err_acc[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_1M024) begin
    if (!rst_n_1M024) begin
      bit_err_q <= '0;
    end else begin
      bit_err_q <= bit_err_d;
    end
  end

  assign bit_err_cnt = bit_err_q;
`else
  assign bit_err_cnt = '0;
`endif

  assign frame_ok  = frame_ok_q;
  assign frame_bad = frame_bad_q;
  assign seq_gap   = seq_gap_q;
  assign locked    = locked_q;
  assign last_seq  = last_seq_q;
  assign ok_cnt    = ok_cnt_q;
  assign bad_cnt   = bad_cnt_q;
  assign gap_cnt   = gap_cnt_q;

endmodule

// File: tb/tb_rx_frame_checker.sv
// Directed self-checking bench for rx_frame_checker (PAYLOAD_LEN=16, CNT_W=4, LOCK_N=4).
module tb_rx_frame_checker;

  localparam int unsigned PL = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned LN = 4;
`ifdef RX_CHK_PATTERN_EN
  localparam int unsigned ExpBitErr = 2;
`else
  localparam int unsigned ExpBitErr = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    tdata;
  logic          tvalid, tuser, tlast, clr;
  logic          frame_ok, frame_bad, seq_gap, locked;
  logic [7:0]    last_seq;
  logic [CW-1:0] ok_cnt, bad_cnt, gap_cnt, bit_err_cnt;

  int total = 0;
  int nbad  = 0;

  always #5 clk = ~clk;

  rx_frame_checker #(
    .PAYLOAD_LEN (PL),
    .CNT_W       (CW),
    .LOCK_N      (LN)
  ) dut (
    .clk_1M024   (clk),
    .rst_n_1M024 (rst_n),
    .data_tdata  (tdata),
    .data_tvalid (tvalid),
    .data_tuser  (tuser),
    .data_tlast  (tlast),
    .clr         (clr),
    .frame_ok    (frame_ok),
    .frame_bad   (frame_bad),
    .seq_gap     (seq_gap),
    .locked      (locked),
    .last_seq    (last_seq),
    .ok_cnt      (ok_cnt),
    .bad_cnt     (bad_cnt),
    .gap_cnt     (gap_cnt),
    .bit_err_cnt (bit_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      nbad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_pulses(input string tag, input logic ok, input logic bad, input logic gap);
    chk({tag, ".frame_ok"}, {31'd0, frame_ok}, {31'd0, ok});
    chk({tag, ".frame_bad"}, {31'd0, frame_bad}, {31'd0, bad});
    chk({tag, ".seq_gap"}, {31'd0, seq_gap}, {31'd0, gap});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat; valid drops afterwards unless the next call re-asserts it.
  task automatic send_beat(input logic [7:0] d, input logic u, input logic l);
    tdata  = d;
    tvalid = 1'b1;
    tuser  = u;
    tlast  = l;
    tick();
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
  endtask

  // Payload and checksum beats; payload byte k = seq+k, optionally bit-flipped.
  task automatic send_tail(input logic [7:0] seq, input logic [7:0] cs_xor,
                           input int flip_k, input logic [7:0] mask);
    logic [7:0] sum;
    logic [7:0] d;
    sum = seq;
    for (int k = 1; k <= int'(PL); k++) begin
      d   = 8'(int'(seq) + k) ^ ((k == flip_k) ? mask : 8'h00);
      sum = sum + d;
      send_beat(d, 1'b0, 1'b0);
    end
    send_beat(sum ^ cs_xor, 1'b0, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] seq, input logic [7:0] cs_xor,
                            input int flip_k, input logic [7:0] mask);
    send_beat(seq, 1'b1, 1'b0);
    send_tail(seq, cs_xor, flip_k, mask);
  endtask

  // n beats of a frame; the final one carries tlast when with_last is set.
  task automatic send_partial(input logic [7:0] seq, input int n, input logic with_last);
    send_beat(seq, 1'b1, 1'b0);
    for (int k = 1; k < n; k++) begin
      send_beat(8'(int'(seq) + k), 1'b0, with_last && (k == n - 1));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    tdata  = 8'h00;
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
    clr    = 1'b0;
    repeat (3) tick();
    chk_pulses("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.locked", {31'd0, locked}, 32'd0);
    chk("reset.last_seq", {24'd0, last_seq}, 32'd0);
    chk("reset.ok_cnt", {28'd0, ok_cnt}, 32'd0);
    chk("reset.bad_cnt", {28'd0, bad_cnt}, 32'd0);
    chk("reset.gap_cnt", {28'd0, gap_cnt}, 32'd0);
    chk("reset.bit_err", {28'd0, bit_err_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Five in-sequence frames; lock appears one cycle after the 4th frame_ok.
    for (int i = 0; i < 5; i++) begin
      send_frame(8'(8'h10 + i), 8'h00, 0, 8'h00);
      chk_pulses("seq10", 1'b1, 1'b0, 1'b0);
      chk("seq10.ok_cnt", {28'd0, ok_cnt}, 32'(i + 1));
      chk("seq10.locked_at_pulse", {31'd0, locked}, {31'd0, (i >= 4)});
      tick();
      chk("seq10.pulse_len", {31'd0, frame_ok}, 32'd0);
      chk("seq10.locked_after", {31'd0, locked}, {31'd0, (i >= 3)});
    end
    chk("seq10.last_seq", {24'd0, last_seq}, 32'h14);
    chk("seq10.gap_cnt", {28'd0, gap_cnt}, 32'd0);

    // 0x20 after 0x14 and 0x22 after 0x20 are both gaps; 0x23 is in order.
    send_frame(8'h20, 8'h00, 0, 8'h00);
    chk_pulses("gap20", 1'b1, 1'b0, 1'b1);
    chk("gap20.gap_cnt", {28'd0, gap_cnt}, 32'd1);
    chk("gap20.locked_at_pulse", {31'd0, locked}, 32'd1);
    tick();
    chk("gap20.locked_after", {31'd0, locked}, 32'd0);
    send_frame(8'h22, 8'h00, 0, 8'h00);
    chk_pulses("gap22", 1'b1, 1'b0, 1'b1);
    chk("gap22.gap_cnt", {28'd0, gap_cnt}, 32'd2);
    chk("gap22.ok_cnt", {28'd0, ok_cnt}, 32'd7);
    send_frame(8'h23, 8'h00, 0, 8'h00);
    chk_pulses("seq23", 1'b1, 1'b0, 1'b0);
    chk("seq23.ok_cnt", {28'd0, ok_cnt}, 32'd8);

    // Corrupt checksum, then a far-off seq re-arms the reference without a gap.
    send_frame(8'h24, 8'h01, 0, 8'h00);
    chk_pulses("cs_bad", 1'b0, 1'b1, 1'b0);
    chk("cs_bad.bad_cnt", {28'd0, bad_cnt}, 32'd1);
    chk("cs_bad.ok_cnt", {28'd0, ok_cnt}, 32'd8);
    chk("cs_bad.last_seq", {24'd0, last_seq}, 32'h23);
    send_frame(8'h30, 8'h00, 0, 8'h00);
    chk_pulses("rearm30", 1'b1, 1'b0, 1'b0);
    chk("rearm30.gap_cnt", {28'd0, gap_cnt}, 32'd2);
    chk("rearm30.last_seq", {24'd0, last_seq}, 32'h30);

    // Early tlast on beat 10, then tuser on beat 5, then a full frame.
    send_partial(8'h3f, 11, 1'b1);
    chk_pulses("early_last", 1'b0, 1'b1, 1'b0);
    chk("early_last.bad_cnt", {28'd0, bad_cnt}, 32'd2);
    send_partial(8'h40, 5, 1'b0);
    send_beat(8'h41, 1'b1, 1'b0);
    chk_pulses("early_user", 1'b0, 1'b1, 1'b0);
    chk("early_user.bad_cnt", {28'd0, bad_cnt}, 32'd3);
    send_tail(8'h41, 8'h00, 0, 8'h00);
    chk_pulses("after_abort", 1'b1, 1'b0, 1'b0);
    chk("after_abort.ok_cnt", {28'd0, ok_cnt}, 32'd10);
    chk("after_abort.last_seq", {24'd0, last_seq}, 32'h41);

    // Bits 0 and 7 of payload byte 3 flipped, checksum still consistent.
    send_frame(8'h42, 8'h00, 3, 8'h81);
    chk_pulses("pattern", 1'b1, 1'b0, 1'b0);
    chk("pattern.ok_cnt", {28'd0, ok_cnt}, 32'd11);
    chk("pattern.bit_err", {28'd0, bit_err_cnt}, 32'(ExpBitErr));

    // tuser and tlast on the same beat is a bad frame.
    send_beat(8'h99, 1'b1, 1'b1);
    chk_pulses("user_last", 1'b0, 1'b1, 1'b0);
    chk("user_last.bad_cnt", {28'd0, bad_cnt}, 32'd4);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr.ok_cnt", {28'd0, ok_cnt}, 32'd0);
    chk("clr.bad_cnt", {28'd0, bad_cnt}, 32'd0);
    chk("clr.gap_cnt", {28'd0, gap_cnt}, 32'd0);
    chk("clr.bit_err", {28'd0, bit_err_cnt}, 32'd0);
    chk("clr.locked", {31'd0, locked}, 32'd0);
    tick();
    chk("clr.locked_after", {31'd0, locked}, 32'd0);

    // 18 back-to-back good frames saturate the 4-bit ok counter.
    for (int i = 0; i < 18; i++) begin
      send_frame(8'(8'h50 + i), 8'h00, 0, 8'h00);
      chk_pulses("sat", 1'b1, 1'b0, 1'b0);
      if (i == 14) chk("sat.ok_cnt_15", {28'd0, ok_cnt}, 32'd15);
    end
    chk("sat.ok_cnt_hold", {28'd0, ok_cnt}, 32'd15);
    chk("sat.gap_cnt", {28'd0, gap_cnt}, 32'd0);
    chk("sat.bad_cnt", {28'd0, bad_cnt}, 32'd0);
    chk("sat.bit_err", {28'd0, bit_err_cnt}, 32'd0);
    chk("sat.last_seq", {24'd0, last_seq}, 32'h61);
    tick();
    chk("sat.locked", {31'd0, locked}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
